// File: rtl/serdes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serdes_pkg
//  Description : Shared comma codes, phase width and aligner state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package serdes_pkg;

    // K28.5 in both running disparities, bit 0 is the first bit on the line
    localparam logic [9:0] COMMA_RDM = 10'h17C;
    localparam logic [9:0] COMMA_RDP = 10'h283;

    localparam int PHASE_W = 4;

    typedef enum logic [1:0] {
        SEARCH   = 2'd0,
        ALIGNING = 2'd1,
        LOCKED   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/comma_detect.sv
`default_nettype none
// ============================================================================
//  Module      : comma_detect
//  Description : Combinational K28.5 match on a 10-bit window, either disparity.
//  Revision    : 1.0 - initial release
// ============================================================================
module comma_detect
    import serdes_pkg::*;
(
    input  logic [9:0] i_window,
    output logic       o_is_comma
);

    assign o_is_comma = (i_window == COMMA_RDM) || (i_window == COMMA_RDP);

endmodule
`default_nettype wire

// File: rtl/rx_comma_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : rx_comma_aligner
//  Description : Serial-to-10b deserializer that locks the word boundary on
//                K28.5 commas and emits aligned words with a valid strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_comma_aligner
    import serdes_pkg::*;
#(
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned LOSS_CNT = 2
) (
    input  logic       CRC_CKL,
    input  logic       RESET,
    input  logic       data_in,
    input  logic       RXPOL,
    output logic [9:0] data_out,
    output logic       word_valid,
    output logic       comma_det,
    output logic       locked,
    output logic       align_err
);

    localparam logic [PHASE_W-1:0] c_PHASE_ONE  = PHASE_W'(1);
    localparam logic [PHASE_W-1:0] c_PHASE_LAST = PHASE_W'(9);
    localparam logic [3:0]         c_LOCK       = 4'(LOCK_CNT);
    localparam logic [3:0]         c_LOSS       = 4'(LOSS_CNT);

    logic [9:0]         r_window;
    logic [PHASE_W-1:0] r_phase;
    state_t             r_state;
    logic [3:0]         r_good_cnt;
    logic [3:0]         r_bad_cnt;

    logic       w_bit;
    logic       w_is_comma;
    logic       w_boundary;
    logic [3:0] w_good_inc;
    logic [3:0] w_bad_inc;

    assign w_bit      = data_in ^ RXPOL;
    assign w_boundary = (r_phase == '0);
    assign w_good_inc = r_good_cnt + 4'd1;
    assign w_bad_inc  = r_bad_cnt + 4'd1;

    comma_detect u_comma_detect (
        .i_window   (r_window),
        .o_is_comma (w_is_comma)
    );

    always_ff @(posedge CRC_CKL) begin
        if (RESET) begin
            r_window   <= '0;
            r_phase    <= '0;
            r_state    <= SEARCH;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
            data_out   <= '0;
            word_valid <= 1'b0;
            comma_det  <= 1'b0;
            locked     <= 1'b0;
            align_err  <= 1'b0;
        end else begin
            r_window   <= {w_bit, r_window[9:1]};
            r_phase    <= (r_phase == c_PHASE_LAST) ? '0 : r_phase + c_PHASE_ONE;
            word_valid <= 1'b0;
            comma_det  <= 1'b0;
            align_err  <= 1'b0;

            case (r_state)
                SEARCH: begin
                    if (w_is_comma) begin
                        r_phase    <= c_PHASE_ONE;
                        r_good_cnt <= 4'd1;
                        // A single required comma locks immediately and emits it
                        if (c_LOCK == 4'd1) begin
                            r_state    <= LOCKED;
                            locked     <= 1'b1;
                            r_bad_cnt  <= '0;
                            data_out   <= r_window;
                            word_valid <= 1'b1;
                            comma_det  <= 1'b1;
                        end else begin
                            r_state <= ALIGNING;
                        end
                    end
                end

                ALIGNING: begin
                    if (w_is_comma && w_boundary) begin
                        r_good_cnt <= w_good_inc;
                        if (w_good_inc == c_LOCK) begin
                            r_state    <= LOCKED;
                            locked     <= 1'b1;
                            r_bad_cnt  <= '0;
                            data_out   <= r_window;
                            word_valid <= 1'b1;
                            comma_det  <= 1'b1;
                        end
                    end else if (w_is_comma) begin
                        r_phase    <= c_PHASE_ONE;
                        r_good_cnt <= 4'd1;
                    end
                end

                LOCKED: begin
                    if (w_boundary) begin
                        data_out   <= r_window;
                        word_valid <= 1'b1;
                        comma_det  <= w_is_comma;
                        if (w_is_comma) begin
                            r_bad_cnt <= '0;
                        end
                    end else if (w_is_comma) begin
                        align_err <= 1'b1;
                        r_bad_cnt <= w_bad_inc;
                        if (w_bad_inc == c_LOSS) begin
                            r_state    <= SEARCH;
                            locked     <= 1'b0;
                            r_good_cnt <= '0;
                        end
                    end
                end

                default: begin
                    r_state <= SEARCH;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
